hdc_ngram_classifier: RTL and testbench

HDC_NGRAM_CLASSIFIER -- requirements
Module: hdc_ngram_classifier

---
 rtl/hdc_ngram_classifier.sv | 237 +++++++++++++++++++++++
 tb/tb_hdc_ngram_classifier.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/hdc_ngram_classifier.sv
// N-gram hyperdimensional text classifier; define HDC_TRAIN_EN to add a training path that stores the bundle as a prototype.
// Result valid NUM_CLASSES+2 cycles after the last token (2 when training); in_ready stays low from the last token until the result is taken.
module hdc_ngram_classifier #(
  parameter int D           = 1024,
  parameter int NGRAM       = 3,
  parameter int NUM_CLASSES = 2,
  parameter int CNT_W       = 8,
  localparam int CLS_W      = $clog2(NUM_CLASSES),
  localparam int DIST_W     = $clog2(D + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [D-1:0]      in_hv,
  input  logic              in_last,
  input  logic              proto_we,
  input  logic [CLS_W-1:0]  proto_addr,
  input  logic [D-1:0]      proto_data,
`ifdef HDC_TRAIN_EN
  input  logic              train_mode,
  input  logic [CLS_W-1:0]  train_tag,
`endif
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CLS_W-1:0]  out_class,
  output logic [DIST_W-1:0] out_dist,
  output logic              out_empty
);

  localparam int FW = $clog2(NGRAM + 1);

  typedef enum logic [2:0] {IDLE, ACCUM, THRESH, CLASSIFY, DONE} state_t;

  state_t              state_q, state_d;
  logic                rdy_en_q;
  logic [FW-1:0]       fill_q, fill_d;
  logic [CNT_W-1:0]    cnt_q [D];
  logic [CNT_W-1:0]    cnt_d [D];
  logic [CNT_W-1:0]    n_q, n_d;
  logic [D-1:0]        bundle_q, bundle_d;
  logic                empty_q, empty_d;
  logic [CLS_W-1:0]    idx_q, idx_d;
  logic [CLS_W-1:0]    best_cls_q, best_cls_d;
  logic [DIST_W-1:0]   best_dist_q, best_dist_d;
  logic [D-1:0]        proto_q [NUM_CLASSES];
  logic                proto_wen;
  logic [CLS_W-1:0]    proto_waddr;
  logic [D-1:0]        proto_wdata;
  logic                in_hs, hist_shift, hist_clr;
  logic [D-1:0]        ngram, bundle_now;
  logic [DIST_W-1:0]   dist_now;
`ifdef HDC_TRAIN_EN
  logic                train_q, train_d;
  logic [CLS_W-1:0]    tag_q, tag_d;
`endif

  function automatic logic [D-1:0] rotl(input logic [D-1:0] x, input int k);
    logic [D-1:0] r;
    r = '0;
    for (int i = 0; i < D; i++) r[(i + k) % D] = x[i];
    return r;
  endfunction

  function automatic logic [DIST_W-1:0] popcount(input logic [D-1:0] x);
    logic [DIST_W-1:0] c;
    c = '0;
    for (int i = 0; i < D; i++) c = c + DIST_W'(x[i]);
    return c;
  endfunction

  // History holds only the previous NGRAM-1 tokens; the current token is in_hv itself.
  if (NGRAM > 1) begin : g_hist
    logic [D-1:0] hist_q [NGRAM-1];
    logic [D-1:0] hist_d [NGRAM-1];

    always_comb begin
      hist_d = hist_q;
      if (hist_clr) begin
        for (int k = 0; k < NGRAM - 1; k++) hist_d[k] = '0;
      end else if (hist_shift) begin
        hist_d[0] = in_hv;
        for (int k = 1; k < NGRAM - 1; k++) hist_d[k] = hist_q[k-1];
      end
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        for (int k = 0; k < NGRAM - 1; k++) hist_q[k] <= '0;
      end else begin
        hist_q <= hist_d;
      end
    end

    always_comb begin
      ngram = in_hv;
      for (int k = 1; k < NGRAM; k++) ngram = ngram ^ rotl(hist_q[k-1], k);
    end
  end else begin : g_nohist
    assign ngram = in_hv;
  end

  assign in_ready  = rdy_en_q && (state_q == IDLE || state_q == ACCUM);
  assign in_hs     = in_valid && in_ready;
  assign out_valid = (state_q == DONE);
  assign out_class = best_cls_q;
  assign out_dist  = best_dist_q;
  assign out_empty = empty_q;
  assign dist_now  = popcount(bundle_q ^ proto_q[idx_q]);

  // Strict majority: a tie (2*cnt == n) and the empty text both give 0.
  always_comb begin
    for (int i = 0; i < D; i++) bundle_now[i] = ({cnt_q[i], 1'b0} > {1'b0, n_q});
  end

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    bundle_d    = bundle_q;
    empty_d     = empty_q;
    idx_d       = idx_q;
    best_cls_d  = best_cls_q;
    best_dist_d = best_dist_q;
    hist_shift  = 1'b0;
    hist_clr    = 1'b0;
    proto_wen   = proto_we && (state_q == IDLE) &&
                  ({1'b0, proto_addr} < (CLS_W + 1)'(NUM_CLASSES));
    proto_waddr = proto_addr;
    proto_wdata = proto_data;
`ifdef HDC_TRAIN_EN
    train_d     = train_q;
    tag_d       = tag_q;
    if (in_hs && state_q == IDLE) begin
      train_d = train_mode;
      tag_d   = train_tag;
    end
`endif

    if (in_hs) begin
      hist_shift = 1'b1;
      if (32'(fill_q) < NGRAM) fill_d = fill_q + FW'(1);
      if (32'(fill_q) + 32'd1 >= 32'(NGRAM)) begin
        for (int i = 0; i < D; i++) begin
          if (ngram[i] && cnt_q[i] != '1) cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
        if (n_q != '1) n_d = n_q + CNT_W'(1);
      end
    end

    case (state_q)
      IDLE, ACCUM: begin
        if (in_hs) state_d = in_last ? THRESH : ACCUM;
      end
      THRESH: begin
        bundle_d = bundle_now;
        empty_d  = (n_q == '0);
        idx_d    = '0;
        state_d  = CLASSIFY;
`ifdef HDC_TRAIN_EN
        if (train_q) begin
          proto_wen   = 1'b1;
          proto_waddr = tag_q;
          proto_wdata = bundle_now;
          best_cls_d  = tag_q;
          best_dist_d = '0;
          state_d     = DONE;
        end
`endif
      end
      CLASSIFY: begin
        // Strictly smaller only, so equal distances keep the lower index.
        if (idx_q == '0 || dist_now < best_dist_q) begin
          best_cls_d  = idx_q;
          best_dist_d = dist_now;
        end
        if (idx_q == CLS_W'(NUM_CLASSES - 1)) state_d = DONE;
        else idx_d = idx_q + CLS_W'(1);
      end
      DONE: begin
        if (out_ready) begin
          state_d  = IDLE;
          fill_d   = '0;
          n_d      = '0;
          hist_clr = 1'b1;
          for (int i = 0; i < D; i++) cnt_d[i] = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      rdy_en_q    <= 1'b0;
      fill_q      <= '0;
      n_q         <= '0;
      bundle_q    <= '0;
      empty_q     <= 1'b0;
      idx_q       <= '0;
      best_cls_q  <= '0;
      best_dist_q <= '0;
      for (int i = 0; i < D; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      rdy_en_q    <= 1'b1;
      fill_q      <= fill_d;
      n_q         <= n_d;
      bundle_q    <= bundle_d;
      empty_q     <= empty_d;
      idx_q       <= idx_d;
      best_cls_q  <= best_cls_d;
      best_dist_q <= best_dist_d;
      cnt_q       <= cnt_d;
    end
  end

`ifdef HDC_TRAIN_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      train_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      train_q <= train_d;
      tag_q   <= tag_d;
    end
  end
`endif

  // Prototype store survives reset so loaded classes are not lost.
  always_ff @(posedge clk) begin
    if (proto_wen) proto_q[proto_waddr] <= proto_wdata;
  end

endmodule

// File: tb/tb_hdc_ngram_classifier.sv
// Directed bench: three D=8, two-class instances with NGRAM = 1, 2, 3 share inputs; each test drives one of them.
module tb_hdc_ngram_classifier;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] in_valid;
  logic [2:0] in_ready;
  logic [7:0] in_hv;
  logic       in_last;
  logic       proto_we;
  logic [0:0] proto_addr;
  logic [7:0] proto_data;
  logic [2:0] out_valid;
  logic       out_ready;
  logic [0:0] out_class [3];
  logic [3:0] out_dist [3];
  logic [2:0] out_empty;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    hdc_ngram_classifier #(
      .D(8), .NGRAM(g + 1), .NUM_CLASSES(2), .CNT_W(8)
    ) u_dut (
      .clk        (clk),
      .reset      (reset),
      .in_valid   (in_valid[g]),
      .in_ready   (in_ready[g]),
      .in_hv      (in_hv),
      .in_last    (in_last),
      .proto_we   (proto_we),
      .proto_addr (proto_addr),
      .proto_data (proto_data),
      .out_valid  (out_valid[g]),
      .out_ready  (out_ready),
      .out_class  (out_class[g]),
      .out_dist   (out_dist[g]),
      .out_empty  (out_empty[g])
    );
  end

  task automatic write_proto(input logic [0:0] a, input logic [7:0] d);
    @(negedge clk);
    proto_we = 1'b1; proto_addr = a; proto_data = d;
    @(negedge clk);
    proto_we = 1'b0;
  endtask

  task automatic send_tok(input int s, input logic [7:0] tok, input logic last);
    int w;
    w = 0;
    @(negedge clk);
    while (!in_ready[s] && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (w >= 20) begin
      total_cnt++;
      $display("FAIL in_ready_timeout dut=%0d in_ready=0 required 1", s);
    end
    in_valid[s] = 1'b1; in_hv = tok; in_last = last;
    @(posedge clk);
  endtask

  // Returns the number of negedges after the last-token edge until out_valid is seen.
  task automatic run_text(input int s, input logic [7:0] t0, input logic [7:0] t1,
                          input logic [7:0] t2, input int n, output int lat);
    for (int i = 0; i < n; i++)
      send_tok(s, (i == 0) ? t0 : (i == 1) ? t1 : t2, i == n - 1);
    lat = 0;
    do begin
      @(negedge clk);
      in_valid[s] = 1'b0; in_last = 1'b0;
      lat++;
    end while (!out_valid[s] && lat < 50);
  endtask

  task automatic accept();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    total_cnt++; if (in_ready !== 3'b000) $display("FAIL rst_in_ready got %b want 000", in_ready); else pass_cnt++;
    total_cnt++; if (out_valid !== 3'b000) $display("FAIL rst_out_valid got %b want 000", out_valid); else pass_cnt++;
    total_cnt++; if (out_class[2] !== 1'b0) $display("FAIL rst_out_class got %0d want 0", out_class[2]); else pass_cnt++;
    total_cnt++; if (out_dist[2] !== 4'd0) $display("FAIL rst_out_dist got %0d want 0", out_dist[2]); else pass_cnt++;
    total_cnt++; if (out_empty !== 3'b000) $display("FAIL rst_out_empty got %b want 000", out_empty); else pass_cnt++;
    reset = 1'b1;
    #1;
    total_cnt++; if (in_ready !== 3'b000) $display("FAIL rst_release_early got %b want 000", in_ready); else pass_cnt++;
    @(posedge clk); #1;
    total_cnt++; if (in_ready !== 3'b111) $display("FAIL rst_release_ready got %b want 111", in_ready); else pass_cnt++;
  endtask

  task automatic test_majority();
    int lat;
    write_proto(1'b0, 8'h0F); write_proto(1'b1, 8'hFF);
    run_text(0, 8'h0F, 8'h0F, 8'hF0, 3, lat);
    total_cnt++; if (lat !== 4) $display("FAIL maj_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_class[0] !== 1'b0) $display("FAIL maj_class got %0d want 0", out_class[0]); else pass_cnt++;
    total_cnt++; if (out_dist[0] !== 4'd0) $display("FAIL maj_dist got %0d want 0", out_dist[0]); else pass_cnt++;
    total_cnt++; if (out_empty[0] !== 1'b0) $display("FAIL maj_empty got %b want 0", out_empty[0]); else pass_cnt++;
    accept();
    total_cnt++; if (out_valid[0] !== 1'b0) $display("FAIL maj_after_accept_valid got %b want 0", out_valid[0]); else pass_cnt++;
    total_cnt++; if (in_ready[0] !== 1'b1) $display("FAIL maj_after_accept_ready got %b want 1", in_ready[0]); else pass_cnt++;
  endtask

  task automatic test_binding();
    int lat;
    write_proto(1'b0, 8'h03); write_proto(1'b1, 8'h00);
    run_text(1, 8'h01, 8'h01, 8'h00, 2, lat);
    total_cnt++; if (lat !== 4) $display("FAIL bind_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_class[1] !== 1'b0) $display("FAIL bind_class got %0d want 0", out_class[1]); else pass_cnt++;
    total_cnt++; if (out_dist[1] !== 4'd0) $display("FAIL bind_dist got %0d want 0", out_dist[1]); else pass_cnt++;
    total_cnt++; if (out_empty[1] !== 1'b0) $display("FAIL bind_empty got %b want 0", out_empty[1]); else pass_cnt++;
    accept();
  endtask

  task automatic test_ties();
    int lat;
    write_proto(1'b0, 8'hFF); write_proto(1'b1, 8'hFF);
    run_text(0, 8'h01, 8'h00, 8'h00, 2, lat);
    total_cnt++; if (lat !== 4) $display("FAIL tie_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_class[0] !== 1'b0) $display("FAIL tie_class got %0d want 0", out_class[0]); else pass_cnt++;
    total_cnt++; if (out_dist[0] !== 4'd8) $display("FAIL tie_dist got %0d want 8", out_dist[0]); else pass_cnt++;
    accept();
  endtask

  task automatic test_short_text();
    int lat;
    write_proto(1'b0, 8'h0F); write_proto(1'b1, 8'h00);
    run_text(2, 8'hAA, 8'h55, 8'h00, 2, lat);
    total_cnt++; if (lat !== 4) $display("FAIL short_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_empty[2] !== 1'b1) $display("FAIL short_empty got %b want 1", out_empty[2]); else pass_cnt++;
    total_cnt++; if (out_class[2] !== 1'b1) $display("FAIL short_class got %0d want 1", out_class[2]); else pass_cnt++;
    total_cnt++; if (out_dist[2] !== 4'd0) $display("FAIL short_dist got %0d want 0", out_dist[2]); else pass_cnt++;
    accept();
  endtask

  // Text 01,01,01 with NGRAM=3 gives n-gram 0x07: distance 1 to 0x0F, 3 to 0x00.
  task automatic test_backpressure_reset();
    int lat;
    run_text(2, 8'h01, 8'h01, 8'h01, 3, lat);
    total_cnt++; if (lat !== 4) $display("FAIL bp_latency got %0d want 4", lat); else pass_cnt++;
    for (int c = 0; c < 5; c++) begin
      // A prototype write while busy must be ignored.
      proto_we = (c == 2); proto_addr = 1'b0; proto_data = 8'hFF;
      @(negedge clk);
      total_cnt++;
      if ({out_valid[2], in_ready[2], out_class[2], out_dist[2], out_empty[2]} !== {1'b1, 1'b0, 1'b0, 4'd1, 1'b0})
        $display("FAIL bp_hold_cycle%0d got valid=%b ready=%b class=%0d dist=%0d empty=%b want 1 0 0 1 0",
                 c, out_valid[2], in_ready[2], out_class[2], out_dist[2], out_empty[2]);
      else pass_cnt++;
    end
    proto_we = 1'b0;
    accept();
    total_cnt++; if (out_valid[2] !== 1'b0) $display("FAIL bp_accept_valid got %b want 0", out_valid[2]); else pass_cnt++;
    send_tok(2, 8'hAA, 1'b0);
    send_tok(2, 8'h55, 1'b0);
    @(negedge clk);
    in_valid[2] = 1'b0;
    reset = 1'b0;
    #1;
    total_cnt++; if (out_valid[2] !== 1'b0) $display("FAIL midrst_valid got %b want 0", out_valid[2]); else pass_cnt++;
    total_cnt++; if (in_ready[2] !== 1'b0) $display("FAIL midrst_ready got %b want 0", in_ready[2]); else pass_cnt++;
    @(negedge clk);
    reset = 1'b1;
    run_text(2, 8'h01, 8'h01, 8'h01, 3, lat);
    total_cnt++; if (lat !== 4) $display("FAIL post_rst_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_class[2] !== 1'b0) $display("FAIL post_rst_class got %0d want 0", out_class[2]); else pass_cnt++;
    total_cnt++; if (out_dist[2] !== 4'd1) $display("FAIL post_rst_dist got %0d want 1", out_dist[2]); else pass_cnt++;
    total_cnt++; if (out_empty[2] !== 1'b0) $display("FAIL post_rst_empty got %b want 0", out_empty[2]); else pass_cnt++;
    accept();
  endtask

  task automatic test_back_to_back();
    int lat;
    write_proto(1'b0, 8'h0F); write_proto(1'b1, 8'hFF);
    out_ready = 1'b1;
    run_text(0, 8'h0F, 8'h0F, 8'hF0, 3, lat);
    total_cnt++; if (lat !== 4) $display("FAIL b2b_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_class[0] !== 1'b0) $display("FAIL b2b_class got %0d want 0", out_class[0]); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid[0] !== 1'b0) $display("FAIL b2b_same_cycle_valid got %b want 0", out_valid[0]); else pass_cnt++;
    total_cnt++; if (in_ready[0] !== 1'b1) $display("FAIL b2b_same_cycle_ready got %b want 1", in_ready[0]); else pass_cnt++;
    run_text(0, 8'hF0, 8'hF0, 8'h0F, 3, lat);
    total_cnt++; if (lat !== 4) $display("FAIL b2b2_latency got %0d want 4", lat); else pass_cnt++;
    total_cnt++; if (out_class[0] !== 1'b1) $display("FAIL b2b2_class got %0d want 1", out_class[0]); else pass_cnt++;
    total_cnt++; if (out_dist[0] !== 4'd4) $display("FAIL b2b2_dist got %0d want 4", out_dist[0]); else pass_cnt++;
    out_ready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b0; in_valid = 3'b000; in_hv = 8'h00; in_last = 1'b0;
    proto_we = 1'b0; proto_addr = 1'b0; proto_data = 8'h00; out_ready = 1'b0;
    test_reset();
    test_majority();
    test_binding();
    test_ties();
    test_short_text();
    test_backpressure_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
